// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: four-stage pipelined floating-point multiplier with generic
// exponent/fraction widths and a valid/ready handshake that stalls the
// whole pipeline when the result is not taken. Subnormal operands are
// treated as zero. Overflow, underflow and invalid are flagged per result.
// Optional macro FPM_ROUND_EN: round-to-nearest-even on the discarded
// product bits; without it the fraction is truncated like the legacy FPM.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   p,
    output logic                   flag_ovf,
    output logic                   flag_unf,
    output logic                   flag_inv
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int PW   = 2 * MAN_W + 2;
    localparam logic signed [EXP_W+1:0] BIAS_S  = (EXP_W+2)'(BIAS);
    localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

    logic advance;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    cls_t cls_d;

    logic                    s1_valid, s1_sign;
    cls_t                    s1_cls;
    logic signed [EXP_W+1:0] s1_exp;
    logic [MAN_W:0]          s1_ma, s1_mb;

    logic                    s2_valid, s2_sign;
    cls_t                    s2_cls;
    logic signed [EXP_W+1:0] s2_exp;
    logic [PW-1:0]           s2_prod;

    logic [PW-1:0]           norm;
    logic signed [EXP_W+1:0] exp_n, exp_d;
    logic [MAN_W-1:0]        frac_d;
`ifdef FPM_ROUND_EN
    logic                    round_up;
    logic [MAN_W+1:0]        mant_r;
`endif

    logic                    s3_valid, s3_sign;
    cls_t                    s3_cls;
    logic signed [EXP_W+1:0] s3_exp;
    logic [MAN_W-1:0]        s3_frac;

    logic signed [EXP_W+1:0] e_unb;
    logic [W-1:0]            p_d;
    logic                    ovf_d, unf_d, inv_d;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Split operands into fields and pick the special-case class by priority
    always_comb begin
        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        fa     = a[MAN_W-1:0];
        fb     = b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero))
            cls_d = CLS_NAN;
        else if (a_inf || b_inf)
            cls_d = CLS_INF;
        else if (a_zero || b_zero)
            cls_d = CLS_ZERO;
        else
            cls_d = CLS_NORM;
    end

    // Stage 1: register class, product sign, biased exponent sum, mantissas
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= CLS_NORM;
            s1_exp   <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= a[W-1] ^ b[W-1];
            s1_cls   <= cls_d;
            s1_exp   <= {2'b00, ea} + {2'b00, eb};
            s1_ma    <= {1'b1, fa};
            s1_mb    <= {1'b1, fb};
        end
    end

    // Stage 2: full-width unsigned mantissa product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_cls   <= CLS_NORM;
            s2_exp   <= '0;
            s2_prod  <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_cls   <= s1_cls;
            s2_exp   <= s1_exp;
            s2_prod  <= {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};
        end
    end

    // Normalise so the hidden bit sits in the product MSB, then round or truncate
    always_comb begin
        norm  = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
        exp_n = s2_exp + {{(EXP_W+1){1'b0}}, s2_prod[PW-1]};
`ifdef FPM_ROUND_EN
        round_up = norm[MAN_W] & (norm[MAN_W+1] | (|norm[MAN_W-1:0]));
        mant_r   = {1'b0, (MAN_W+1)'(norm >> (MAN_W+1))} + {{(MAN_W+1){1'b0}}, round_up};
        if (mant_r[MAN_W+1]) begin
            frac_d = mant_r[MAN_W:1];
            exp_d  = exp_n + {{(EXP_W+1){1'b0}}, 1'b1};
        end else begin
            frac_d = mant_r[MAN_W-1:0];
            exp_d  = exp_n;
        end
`else
        frac_d = MAN_W'(norm >> (MAN_W+1));
        exp_d  = exp_n;
`endif
    end

    // Stage 3: register the normalised fraction and adjusted exponent sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_sign  <= 1'b0;
            s3_cls   <= CLS_NORM;
            s3_exp   <= '0;
            s3_frac  <= '0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_sign  <= s2_sign;
            s3_cls   <= s2_cls;
            s3_exp   <= exp_d;
            s3_frac  <= frac_d;
        end
    end

    // Remove the bias, range-check and pack; bubbles produce an all-zero word
    always_comb begin
        p_d   = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inv_d = 1'b0;
        e_unb = s3_exp - BIAS_S;
        if (s3_valid) begin
            case (s3_cls)
                CLS_NAN: begin
                    p_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                    inv_d = 1'b1;
                end
                CLS_INF:  p_d = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                CLS_ZERO: p_d = {s3_sign, {(W-1){1'b0}}};
                default: begin
                    if (e_unb >= EXP_MAX) begin
                        p_d   = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ovf_d = 1'b1;
                    end else if (e_unb[EXP_W+1] || (e_unb == '0)) begin
                        p_d   = {s3_sign, {(W-1){1'b0}}};
                        unf_d = 1'b1;
                    end else begin
                        p_d = {s3_sign, e_unb[EXP_W-1:0], s3_frac};
                    end
                end
            endcase
        end
    end

    // Stage 4: output register, held while the consumer is not ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            p         <= '0;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_inv  <= 1'b0;
        end else if (advance) begin
            out_valid <= s3_valid;
            p         <= p_d;
            flag_ovf  <= ovf_d;
            flag_unf  <= unf_d;
            flag_inv  <= inv_d;
        end
    end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point multiplier; next generation of the team's fixed 32-bit FPM.
- Generic exponent/mantissa widths, valid/ready handshake with stall, and asynchronous reset.
- Handles special operands (zero, infinity, NaN), flushes subnormals to zero, and reports overflow, underflow and invalid flags per result.
- Sits in the arithmetic datapath; feeds accumulators and other downstream consumers.

Parameters:
- EXP_W, 8, exponent field width (bits).
- MAN_W, 23, stored fraction width (bits, hidden bit excluded).
- Derived, not overridable: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  pipeline can accept operands this cycle
- a  input  W  operand A (sign|exponent|fraction)
- b  input  W  operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- p  output  W  product
- flag_ovf  output  1  result overflowed to infinity
- flag_unf  output  1  result underflowed, flushed to zero
- flag_inv  output  1  invalid operation (NaN input, or 0 x inf)

Behaviour:
- Reset: all stage valid bits, out_valid, p and all flags clear to 0 immediately, independent of clk. In-flight operations are discarded.
- Pipeline: 4 stages, latency 4 cycles from accepted input to out_valid when unstalled. Throughput is 1 per cycle.
  - S1: unpack, classify, XOR signs, form the sum of biased exponents (EXP_W+2 bits, signed).
  - S2: (MAN_W+1)x(MAN_W+1) unsigned mantissa product, 2*MAN_W+2 bits.
  - S3: normalise (product MSB set: shift right 1, exponent+1), round, renormalise if rounding carries out.
  - S4: subtract BIAS, range check, pack, set flags.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - When advance=0, every stage register holds, including valid bits and data.
  - Input is accepted when in_valid & in_ready. out_valid with p/flags stays stable until out_ready.
  - Bubbles propagate as valid=0 stages. No combinational path from in_valid to out_valid.
- Classification (exponent field E, fraction F):
  - E=0: zero; subnormals are treated as zero.
  - E=all-ones, F=0: infinity.
  - E=all-ones, F!=0: NaN.
- Special results, checked in priority order:
  - Any NaN, or zero x inf: canonical NaN (sign 0, E all-ones, fraction MSB 1, rest 0); flag_inv=1.
  - Inf x nonzero: infinity with XOR sign.
  - Zero x finite: zero with XOR sign.
- Range: unbiased result exponent e = Ea+Eb-BIAS after normalisation and rounding.
  - e >= 2^EXP_W-1: signed infinity, flag_ovf=1.
  - e <= 0: signed zero, flag_unf=1.
- Flags are valid only with out_valid. At most one of ovf/unf/inv is set per result.
- No bypass of the latency: special-case results also take 4 cycles.

Optional Feature:
- Macro FPM_ROUND_EN.
- Defined: round-to-nearest-even using guard, round and sticky bits from the discarded product bits. A rounding carry-out renormalises and increments the exponent, which may trigger overflow.
- Undefined: truncation, matching the legacy FPM. The rounding adder is removed; latency stays 4 cycles.

Test Plan:
- Reset mid-stream: stream 3 pairs, assert rst on cycle 2 -> outputs 0 at once; no out_valid appears after release.
- Basic (defaults): a=0x3FC00000, b=0x40000000 -> p=0x40400000 exactly 4 cycles after acceptance; no flags.
- Specials: 0x7F800000 x 0x00000000 -> p=0x7FC00000, flag_inv=1. 0xFF800000 x 0x40000000 -> p=0xFF800000, no flags. 0x00000001 x 0x3F800000 -> p=0x00000000.
- Range: 0x7F000000 x 0x7F000000 -> p=0x7F800000, flag_ovf=1. 0x00800000 x 0x3F000000 -> p=0x00000000, flag_unf=1.
- Rounding: 0x3F800001 x 0x3FC00000 -> p=0x3FC00002 with FPM_ROUND_EN, 0x3FC00001 without.
- Stall: back-to-back 8 inputs, out_ready low for 3 cycles mid-stream -> in_ready low during the stall. All 8 results appear in order, none lost or duplicated, and p stays stable while out_valid & !out_ready.
